// File: rtl/saf_pkt_buffer.sv
// Store-and-forward packet buffer: packets become readable only once their
// final word commits without an error flag; errored or oversize packets are rewound.
module saf_pkt_buffer #(
   parameter int DEPTH_LG2  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wren_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  eop_i,
   output logic                  full_o,
   output logic                  pkt_avail_o,
   input  logic                  rden_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  reop_o,
   output logic [DEPTH_LG2:0]    pkt_cnt_o,
   output logic [7:0]            drop_cnt_o
);

   localparam int DEPTH = 2**DEPTH_LG2;
   localparam logic [DEPTH_LG2:0] DEPTH_W = (DEPTH_LG2+1)'(DEPTH);
   localparam logic [DEPTH_LG2:0] PTR_ONE = (DEPTH_LG2+1)'(1);

   typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

   state_t                r_state;
   logic [DEPTH_LG2:0]    r_wr_ptr;
   logic [DEPTH_LG2:0]    r_commit_ptr;
   logic [DEPTH_LG2:0]    r_rd_ptr;
   logic [DEPTH_LG2:0]    r_pkt_cnt;
   logic [7:0]            r_drop_cnt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_eop_mem;

   logic                  w_full;
   logic                  w_accept;
   logic                  w_overflow;
   logic                  w_commit;
   logic                  w_rd;
   logic                  w_rd_eop;
   logic [DEPTH_LG2:0]    w_used;
   logic [7:0]            w_drop_inc;

   assign w_used     = r_wr_ptr - r_rd_ptr;
   assign w_full     = (w_used == DEPTH_W);
   assign w_accept   = wren_i & ~w_full & (r_state != DROP);
   assign w_overflow = wren_i &  w_full & (r_state != DROP);
   assign w_commit   = w_accept & eop_i & ~wdata_i[0];
   assign w_rd       = rden_i & (r_pkt_cnt != '0);
   // eop flags live in flops so the packet count can react in the read cycle
   assign w_rd_eop   = w_rd & r_eop_mem[r_rd_ptr[DEPTH_LG2-1:0]];
   assign w_drop_inc = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;

   assign full_o      = w_full;
   assign pkt_avail_o = (r_pkt_cnt != '0);
   assign pkt_cnt_o   = r_pkt_cnt;
   assign drop_cnt_o  = r_drop_cnt;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr[DEPTH_LG2-1:0]]     <= wdata_i;
         r_eop_mem[r_wr_ptr[DEPTH_LG2-1:0]] <= eop_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_drop_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE, WRITE: begin
               if (w_overflow) begin
                  r_wr_ptr   <= r_commit_ptr;
                  r_drop_cnt <= w_drop_inc;
                  r_state    <= eop_i ? IDLE : DROP;
               end else if (w_accept) begin
                  if (!eop_i) begin
                     r_wr_ptr <= r_wr_ptr + PTR_ONE;
                     r_state  <= WRITE;
                  end else if (wdata_i[0]) begin
                     r_wr_ptr   <= r_commit_ptr;
                     r_drop_cnt <= w_drop_inc;
                     r_state    <= IDLE;
                  end else begin
                     r_wr_ptr     <= r_wr_ptr + PTR_ONE;
                     r_commit_ptr <= r_wr_ptr + PTR_ONE;
                     r_state      <= IDLE;
                  end
               end
            end
            DROP: begin
               if (wren_i && eop_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         reop_o   <= 1'b0;
      end else begin
         rvalid_o <= w_rd;
         if (w_rd) begin
            rdata_o  <= r_mem[r_rd_ptr[DEPTH_LG2-1:0]];
            reop_o   <= r_eop_mem[r_rd_ptr[DEPTH_LG2-1:0]];
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt <= '0;
      end else begin
         case ({w_commit, w_rd_eop})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + PTR_ONE;
            2'b01:   r_pkt_cnt <= r_pkt_cnt - PTR_ONE;
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_saf_pkt_buffer.sv
// Scoreboard bench: a queue-based packet model predicts status and read data;
// a separate monitor checks every read beat as it appears.
module tb_saf_pkt_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wren_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic        eop_i = 1'b0;
   logic        full_o;
   logic        pkt_avail_o;
   logic        rden_i = 1'b0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        reop_o;
   logic [4:0]  pkt_cnt_o;
   logic [7:0]  drop_cnt_o;

   saf_pkt_buffer #(.DEPTH_LG2(4), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .wren_i(wren_i), .wdata_i(wdata_i), .eop_i(eop_i),
      .full_o(full_o), .pkt_avail_o(pkt_avail_o), .rden_i(rden_i), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .reop_o(reop_o), .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: committed words awaiting read, the packet being assembled,
   // whether the rest of an overflowed packet is being discarded.
   logic [32:0] committed[$];
   logic [31:0] partial[$];
   logic [32:0] exp_q[$];
   int          m_pkt = 0;
   int          m_drop = 0;
   bit          m_dropping = 0;
   logic [31:0] last_rdata = '0;
   logic        last_reop = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int occupancy();
      return partial.size() + committed.size();
   endfunction

   task automatic step(input bit w, input logic [31:0] d, input bit e, input bit r);
      bit          was_full;
      logic [32:0] tmp;
      was_full = (occupancy() == 16);
      wren_i = w; wdata_i = d; eop_i = e; rden_i = r;
      if (r && m_pkt != 0) begin
         tmp = committed.pop_front();
         exp_q.push_back(tmp);
         if (tmp[32]) m_pkt--;
      end
      if (w) begin
         if (m_dropping) begin
            if (e) m_dropping = 0;
         end else if (was_full) begin
            partial.delete();
            if (m_drop < 255) m_drop++;
            m_dropping = !e;
         end else begin
            partial.push_back(d);
            if (e) begin
               if (d[0]) begin
                  if (m_drop < 255) m_drop++;
               end else begin
                  for (int i = 0; i < partial.size(); i++)
                     committed.push_back({(i == partial.size() - 1), partial[i]});
                  m_pkt++;
               end
               partial.delete();
            end
         end
      end
      @(negedge clk);
      check("full_o", 32'(full_o), 32'(occupancy() == 16));
      check("pkt_cnt_o", 32'(pkt_cnt_o), 32'(m_pkt));
      check("pkt_avail_o", 32'(pkt_avail_o), 32'(m_pkt != 0));
      check("drop_cnt_o", 32'(drop_cnt_o), 32'(m_drop));
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, r);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      wren_i = 1'b0; rden_i = 1'b0; eop_i = 1'b0; wdata_i = '0;
      #1;
      check("rst rvalid_o", 32'(rvalid_o), 32'h0);
      check("rst rdata_o", rdata_o, 32'h0);
      check("rst reop_o", 32'(reop_o), 32'h0);
      check("rst full_o", 32'(full_o), 32'h0);
      check("rst pkt_avail_o", 32'(pkt_avail_o), 32'h0);
      check("rst pkt_cnt_o", 32'(pkt_cnt_o), 32'h0);
      check("rst drop_cnt_o", 32'(drop_cnt_o), 32'h0);
      committed.delete(); partial.delete(); exp_q.delete();
      m_pkt = 0; m_drop = 0; m_dropping = 0;
      last_rdata = '0; last_reop = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every read beat must match the oldest predicted word; outputs hold otherwise.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n) begin
         if (rvalid_o) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rvalid: got rdata %0h expected no read", rdata_o);
            end else begin
               e = exp_q.pop_front();
               check("rdata_o", rdata_o, e[31:0]);
               check("reop_o", 32'(reop_o), 32'(e[32]));
               last_rdata = rdata_o;
               last_reop  = reop_o;
            end
         end else begin
            check("rdata_hold", rdata_o, last_rdata);
            check("reop_hold", 32'(reop_o), 32'(last_reop));
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      do_reset();

      // Three-word good packet read back with rden_i held
      step(1, 32'hA0A0_0010, 0, 0);
      step(1, 32'hB0B0_0020, 0, 0);
      step(1, 32'hC0C0_0030, 1, 0);
      idle(5, 1);

      // Errored packet is rewound and counted
      step(1, 32'h1111_0000, 0, 0);
      step(1, 32'h2222_0000, 0, 0);
      step(1, 32'h3333_0001, 1, 0);
      idle(3, 1);

      // Oversize packet: 16 fill the buffer, the 17th overflows, rest ignored
      for (int i = 0; i < 17; i++) step(1, 32'h5000_0000 + 32'(i * 2), 0, 0);
      step(1, 32'h6000_0000, 0, 0);
      step(1, 32'h6000_0002, 1, 0);
      step(1, 32'h7000_0002, 0, 0);
      step(1, 32'h7000_0004, 0, 0);
      step(1, 32'h7000_0006, 1, 0);
      idle(5, 1);

      // Commit of packet 2 coincides with reading packet 1's eop
      step(1, 32'h8000_0002, 0, 0);
      step(1, 32'h8000_0004, 1, 0);
      step(1, 32'h9000_0002, 0, 1);
      step(1, 32'h9000_0004, 1, 1);
      idle(4, 1);

      // Reset mid-packet with a committed packet stored, then restart cleanly
      step(1, 32'hAA00_0002, 1, 0);
      step(1, 32'hBB00_0002, 0, 0);
      step(1, 32'hBB00_0004, 0, 0);
      do_reset();
      step(1, 32'hCC00_0002, 0, 0);
      step(1, 32'hCC00_0004, 1, 0);
      idle(4, 1);

      // Drop counter saturation
      for (int i = 0; i < 260; i++) step(1, 32'hE000_0001 + 32'(i * 2), 1, 0);
      do_reset();

      // Randomized traffic: read-starved first half exercises full/overflow
      for (int i = 0; i < 3000; i++) begin
         bit          w, e, r;
         logic [31:0] d;
         w = ($urandom_range(0, 9) < 7);
         e = ($urandom_range(0, 5) == 0);
         d = $urandom;
         if (e) d[0] = ($urandom_range(0, 3) == 0);
         r = (i < 1500) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
         step(w, d, e, r);
      end
      idle(40, 1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
